// File: rtl/audio_pkg.sv
// Shared types and helpers for the SPRAM-backed audio delay scheduler.
package audio_pkg;

  localparam int DEF_ADDRLEN   = 14;
  localparam int DEF_DATALEN   = 16;
  localparam int CYCLES_PER_CH = 4;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    WAIT,
    CAP,
    DONE
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/delay_addr_gen.sv
// Maps a channel index, the shared write pointer and that channel's delay
// onto SPRAM write/read addresses inside the channel's private region.
module delay_addr_gen #(
  parameter int ADDRLEN = 14,
  parameter int CHLEN   = 13,
  parameter int CW      = 1
) (
  input  logic [CW-1:0]      ch_idx,
  input  logic [CHLEN-1:0]   wr_ptr,
  input  logic [CHLEN-1:0]   ch_delay,
  output logic [ADDRLEN-1:0] wr_addr,
  output logic [ADDRLEN-1:0] rd_addr
);

  logic [ADDRLEN-1:0] base;
  logic [CHLEN-1:0]   rd_off;

  // The subtract is kept CHLEN bits wide so a read wraps inside its own region.
  always_comb begin
    base    = ADDRLEN'(ch_idx) << CHLEN;
    rd_off  = wr_ptr - ch_delay;
    wr_addr = base | ADDRLEN'(wr_ptr);
    rd_addr = base | ADDRLEN'(rd_off);
  end

endmodule

// File: rtl/spram_delay_scheduler.sv
// Time-shares one single-port SPRAM among NCH delay lines: once per frame each
// channel writes its new sample, then reads back the sample delay[c] frames old.
module spram_delay_scheduler
  import audio_pkg::*;
#(
  parameter int ADDRLEN = DEF_ADDRLEN,
  parameter int DATALEN = DEF_DATALEN,
  parameter int NCH     = 2,
  parameter int CHLEN   = ADDRLEN - clog2(NCH)
) (
  input  logic                   bclk,
  input  logic                   reset,
  input  logic                   lrclk,
  input  logic [NCH*DATALEN-1:0] ch_in,
  input  logic [NCH*CHLEN-1:0]   delay,
  output logic [NCH*DATALEN-1:0] ch_out,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   overrun,
  output logic [ADDRLEN-1:0]     mem_addr,
  output logic [DATALEN-1:0]     mem_din,
  output logic                   mem_wren,
  input  logic [DATALEN-1:0]     mem_dout
);

  localparam int CW = (NCH > 1) ? clog2(NCH) : 1;

  state_t             state;
  state_t             next_state;
  logic               lrclk_d;
  logic               start;
  logic               last_ch;
  logic [CW-1:0]      c;
  logic [CHLEN-1:0]   wr_ptr;
  logic [CHLEN-1:0]   cur_delay;
  logic [ADDRLEN-1:0] wr_addr;
  logic [ADDRLEN-1:0] rd_addr;

  assign start     = lrclk & ~lrclk_d;
  assign last_ch   = (c == CW'(NCH - 1));
  assign cur_delay = delay[c*CHLEN +: CHLEN];
  assign busy      = (state != IDLE);

  delay_addr_gen #(
    .ADDRLEN (ADDRLEN),
    .CHLEN   (CHLEN),
    .CW      (CW)
  ) u_addr_gen (
    .ch_idx   (c),
    .wr_ptr   (wr_ptr),
    .ch_delay (cur_delay),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr)
  );

  always_ff @(posedge bclk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = WR;
      WR:      next_state = RD;
      RD:      next_state = WAIT;
      WAIT:    next_state = CAP;
      CAP:     next_state = last_ch ? DONE : WR;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // out_valid is registered off DONE, so it lines up with the final ch_out word.
  always_ff @(posedge bclk) begin
    if (reset) begin
      lrclk_d   <= 1'b0;
      c         <= '0;
      wr_ptr    <= '0;
      ch_out    <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      mem_wren  <= 1'b0;
    end else begin
      lrclk_d   <= lrclk;
      out_valid <= 1'b0;
      if (start && (state != IDLE)) overrun <= 1'b1;
      case (state)
        WR: begin
          mem_addr <= wr_addr;
          mem_din  <= ch_in[c*DATALEN +: DATALEN];
          mem_wren <= 1'b1;
        end
        RD: begin
          mem_addr <= rd_addr;
          mem_wren <= 1'b0;
        end
        CAP: begin
          ch_out[c*DATALEN +: DATALEN] <= mem_dout;
          if (!last_ch) c <= c + 1'b1;
        end
        DONE: begin
          out_valid <= 1'b1;
          wr_ptr    <= wr_ptr + 1'b1;
          c         <= '0;
        end
        default: mem_wren <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_spram_delay_scheduler.sv
// Scoreboard bench for spram_delay_scheduler with a behavioural SPRAM model,
// run with a shrunk 64-word memory so pointer wrap is reachable quickly.
module tb_spram_delay_scheduler;
  import audio_pkg::*;

  localparam int ADDRLEN = 6;
  localparam int DATALEN = 16;
  localparam int NCH     = 2;
  localparam int CHLEN   = 5;
  localparam int LATENCY = CYCLES_PER_CH * NCH + 2;

  logic                   bclk = 1'b0;
  logic                   reset = 1'b1;
  logic                   lrclk = 1'b0;
  logic [NCH*DATALEN-1:0] ch_in = '0;
  logic [NCH*CHLEN-1:0]   delay = '0;
  logic [NCH*DATALEN-1:0] ch_out;
  logic                   out_valid;
  logic                   busy;
  logic                   overrun;
  logic [ADDRLEN-1:0]     mem_addr;
  logic [DATALEN-1:0]     mem_din;
  logic                   mem_wren;
  logic [DATALEN-1:0]     mem_dout;

  logic [DATALEN-1:0] mem [0:(1<<ADDRLEN)-1];

  typedef struct {
    logic [31:0] exp;
    logic [1:0]  mask;
    int          start;
  } item_t;

  item_t       sb_q[$];
  item_t       mon_item;
  int          checks = 0;
  int          errors = 0;
  int          valid_count = 0;
  int          cyc = 0;
  int          frame_idx = 0;
  logic [4:0]  cur_ptr = '0;

  spram_delay_scheduler #(
    .ADDRLEN (ADDRLEN),
    .DATALEN (DATALEN),
    .NCH     (NCH)
  ) dut (
    .bclk      (bclk),
    .reset     (reset),
    .lrclk     (lrclk),
    .ch_in     (ch_in),
    .delay     (delay),
    .ch_out    (ch_out),
    .out_valid (out_valid),
    .busy      (busy),
    .overrun   (overrun),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_wren  (mem_wren),
    .mem_dout  (mem_dout)
  );

  always #5 bclk = ~bclk;

  always @(posedge bclk) cyc <= cyc + 1;

  always @(posedge bclk) begin
    if (mem_wren) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  task automatic tick(input int n);
    repeat (n) @(posedge bclk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Channel 1 samples always carry bit 8 set, which identifies the region a write must hit.
  always @(negedge bclk) begin
    if (mem_wren)
      checkOutput("wr_addr", 32'(mem_addr), {26'b0, mem_din[8], cur_ptr});
    if (out_valid) begin
      valid_count++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_out_valid: got out_valid=%0b at cycle %0d, expected none",
                 out_valid, cyc);
      end else begin
        mon_item = sb_q.pop_front();
        checkOutput("latency", 32'(cyc - mon_item.start), 32'(LATENCY));
        if (mon_item.mask[0]) checkOutput("ch0_out", 32'(ch_out[15:0]), 32'(mon_item.exp[15:0]));
        if (mon_item.mask[1]) checkOutput("ch1_out", 32'(ch_out[31:16]), 32'(mon_item.exp[31:16]));
      end
    end
  end

  task automatic applyReset();
    reset = 1'b1;
    lrclk = 1'b0;
    ch_in = '0;
    tick(2);
    reset     = 1'b0;
    frame_idx = 0;
    cur_ptr   = '0;
  endtask

  task automatic checkResetState();
    checkOutput("rst_ch_out",    ch_out,             32'd0);
    checkOutput("rst_out_valid", 32'(out_valid),     32'd0);
    checkOutput("rst_busy",      32'(busy),          32'd0);
    checkOutput("rst_overrun",   32'(overrun),       32'd0);
    checkOutput("rst_mem_addr",  32'(mem_addr),      32'd0);
    checkOutput("rst_mem_din",   32'(mem_din),       32'd0);
    checkOutput("rst_mem_wren",  32'(mem_wren),      32'd0);
  endtask

  task automatic applyStimulus(input logic [15:0] s0, input logic [15:0] s1,
                               input logic [1:0] m, input logic [15:0] e0,
                               input logic [15:0] e1);
    cur_ptr = 5'(frame_idx);
    ch_in   = {s1, s0};
    lrclk   = 1'b1;
    sb_q.push_back('{exp: {e1, e0}, mask: m, start: cyc});
    tick(32);
    lrclk = 1'b0;
    tick(32);
    frame_idx++;
  endtask

  initial begin
    int bad;
    int vcount0;

    $display("[TB] reset and idle");
    tick(1);
    applyReset();
    checkResetState();
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge bclk);
      if (mem_wren || out_valid) bad++;
    end
    checkOutput("idle_quiet", 32'(bad), 32'd0);
    tick(1);

    $display("[TB] delays ch0=3 ch1=1");
    delay = {5'd1, 5'd3};
    for (int n = 0; n < 10; n++)
      applyStimulus(16'(n), 16'(256 + n), {(n >= 1), (n >= 3)},
                    16'(n - 3), 16'(256 + n - 1));

    $display("[TB] zero delay");
    applyReset();
    delay = '0;
    for (int n = 0; n < 5; n++)
      applyStimulus(16'(64 + n), 16'(448 + n), 2'b11, 16'(64 + n), 16'(448 + n));

    $display("[TB] pointer wrap, delay 31");
    applyReset();
    delay = {5'd31, 5'd31};
    for (int n = 0; n < 40; n++)
      applyStimulus(16'(n), 16'(256 + n), {(n >= 31), (n >= 31)},
                    16'(n - 31), 16'(256 + n - 31));

    $display("[TB] overrun");
    applyReset();
    delay   = '0;
    cur_ptr = '0;
    vcount0 = valid_count;
    ch_in   = {16'h01AA, 16'h00AA};
    lrclk   = 1'b1;
    sb_q.push_back('{exp: {16'h01AA, 16'h00AA}, mask: 2'b11, start: cyc});
    tick(1);
    lrclk = 1'b0;
    tick(1);
    checkOutput("overrun_before", 32'(overrun), 32'd0);
    tick(1);
    lrclk = 1'b1;
    tick(1);
    checkOutput("overrun_set", 32'(overrun), 32'd1);
    tick(36);
    lrclk = 1'b0;
    tick(30);
    checkOutput("overrun_sticky", 32'(overrun), 32'd1);
    checkOutput("overrun_valid_count", 32'(valid_count - vcount0), 32'd1);
    frame_idx++;
    applyReset();
    checkOutput("overrun_cleared", 32'(overrun), 32'd0);

    $display("[TB] reset during RD of channel 1");
    delay = '0;
    applyStimulus(16'h0011, 16'h0111, 2'b11, 16'h0011, 16'h0111);
    cur_ptr = 5'(frame_idx);
    ch_in   = {16'h0122, 16'h0022};
    lrclk   = 1'b1;
    tick(6);
    checkOutput("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    tick(1);
    checkOutput("abort_busy",      32'(busy),      32'd0);
    checkOutput("abort_mem_wren",  32'(mem_wren),  32'd0);
    checkOutput("abort_ch_out",    ch_out,         32'd0);
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    reset     = 1'b0;
    lrclk     = 1'b0;
    frame_idx = 0;
    cur_ptr   = '0;
    tick(40);
    applyStimulus(16'h0033, 16'h0133, 2'b11, 16'h0033, 16'h0133);
    delay = {5'd1, 5'd1};
    applyStimulus(16'h0044, 16'h0144, 2'b11, 16'h0033, 16'h0133);

    tick(10);
    checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
